// File: rtl/pc_fetch_stage.sv
// IF stage: owns the PC, the variable-latency fetch handshake and the IF/ID register.
// A fetch orphaned by a redirect is drained in DISCARD rather than cancelled.
module pc_fetch_stage #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  is_branch,
   input  logic [ADDR_WIDTH-1:0] branch_address,
   input  logic                  is_rst_IF_ID,
   output logic                  inst_req,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic [DATA_WIDTH-1:0] inst_rdata,
   input  logic                  inst_ready,
   output logic [ADDR_WIDTH-1:0] pc_plus4_ID,
   output logic [DATA_WIDTH-1:0] inst_ID,
   output logic                  valid_ID
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD, S_HOLD} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] disc_addr_q, disc_addr_d;
   logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;
   logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;
   logic                  valid_q, valid_d;

   logic                  redirect, flush;
   logic                  bubble, load;
   logic [DATA_WIDTH-1:0] load_word;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign redirect = is_branch & ~stall;
   assign flush    = (is_branch | is_rst_IF_ID) & ~stall;
   assign pc_inc   = pc_q + ADDR_WIDTH'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      hold_inst_d = hold_inst_q;
      pc_plus4_d  = pc_plus4_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      bubble      = 1'b0;
      load        = 1'b0;
      load_word   = '0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (redirect) begin
               pc_d   = branch_address;
               bubble = 1'b1;
               // Memory cannot be cancelled: remember the orphan's address and drain it.
               if (!inst_ready) begin
                  disc_addr_d = pc_q;
                  state_d     = S_DISCARD;
               end
            end else if (inst_ready && !stall) begin
               load      = 1'b1;
               load_word = inst_rdata;
               pc_d      = pc_inc;
            end else if (inst_ready) begin
               hold_inst_d = inst_rdata;
               state_d     = S_HOLD;
            end else if (flush || !stall) begin
               bubble = 1'b1;
            end
         end
         S_DISCARD: begin
            if (flush || !stall) bubble = 1'b1;
            if (redirect)   pc_d    = branch_address;
            if (inst_ready) state_d = S_FETCH;
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = branch_address;
               bubble  = 1'b1;
               state_d = S_FETCH;
            end else if (!stall) begin
               load      = 1'b1;
               load_word = hold_inst_q;
               pc_d      = pc_inc;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bubble) begin
         pc_plus4_d = '0;
         inst_d     = '0;
         valid_d    = 1'b0;
      end else if (load) begin
         pc_plus4_d = pc_inc;
         inst_d     = load_word;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         disc_addr_q <= '0;
         hold_inst_q <= '0;
         pc_plus4_q  <= '0;
         inst_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         hold_inst_q <= hold_inst_d;
         pc_plus4_q  <= pc_plus4_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
      end
   end

   assign inst_req    = rst & ((state_q == S_FETCH) | (state_q == S_DISCARD));
   assign inst_addr   = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
   assign pc_plus4_ID = pc_plus4_q;
   assign inst_ID     = inst_q;
   assign valid_ID    = valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, a drain/retarget sequence,
// then random traffic against a transaction-level reference model.
module tb_pc_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, is_branch, is_rst_IF_ID, inst_ready;
   logic [31:0] branch_address, inst_rdata;
   logic        inst_req, valid_ID;
   logic [31:0] inst_addr, pc_plus4_ID, inst_ID;
   logic        w_req, w_vld;
   logic [31:0] w_addr, w_pc4, w_inst;

   pc_fetch_stage u_dut (
      .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch),
      .branch_address(branch_address), .is_rst_IF_ID(is_rst_IF_ID),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
      .inst_ready(inst_ready), .pc_plus4_ID(pc_plus4_ID), .inst_ID(inst_ID),
      .valid_ID(valid_ID)
   );

   // Second instance shares the stimulus; only its first cycles are checked (PC wrap from reset).
   pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch),
      .branch_address(branch_address), .is_rst_IF_ID(is_rst_IF_ID),
      .inst_req(w_req), .inst_addr(w_addr), .inst_rdata(inst_rdata),
      .inst_ready(inst_ready), .pc_plus4_ID(w_pc4), .inst_ID(w_inst),
      .valid_ID(w_vld)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_started, m_drop;
   logic [31:0] m_pc, m_daddr, e_pc4, e_inst;
   logic        e_vld;
   logic [31:0] skid[$];

   function automatic void set_ifid(logic [31:0] p4, logic [31:0] w, logic v);
      e_pc4 = p4; e_inst = w; e_vld = v;
   endfunction

   function automatic void model_step(logic r, logic st, logic br, logic [31:0] tgt,
                                      logic rdy, logic [31:0] rd);
      logic redir;
      redir = br & ~st;
      if (!r) begin
         m_started = 0; m_drop = 0; m_pc = 32'h0; m_daddr = 32'h0;
         skid.delete(); set_ifid(0, 0, 0);
         return;
      end
      if (!m_started) begin
         m_started = 1;
         return;
      end
      if (skid.size() != 0) begin
         if (redir) begin
            m_pc = tgt; set_ifid(0, 0, 0); skid.delete();
         end else if (!st) begin
            set_ifid(m_pc + 32'd4, skid[0], 1); m_pc = m_pc + 32'd4; skid.delete();
         end
      end else if (m_drop) begin
         if (!st)   set_ifid(0, 0, 0);
         if (redir) m_pc = tgt;
         if (rdy)   m_drop = 0;
      end else begin
         if (redir) begin
            if (!rdy) begin m_drop = 1; m_daddr = m_pc; end
            m_pc = tgt; set_ifid(0, 0, 0);
         end else if (rdy && !st) begin
            set_ifid(m_pc + 32'd4, rd, 1); m_pc = m_pc + 32'd4;
         end else if (rdy) begin
            skid.push_back(rd);
         end else if (!st) begin
            set_ifid(0, 0, 0);
         end
      end
   endfunction

   function automatic logic exp_req();
      return m_started && (skid.size() == 0);
   endfunction

   function automatic logic [31:0] exp_addr();
      return (m_started && m_drop) ? m_daddr : m_pc;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(rst, stall, is_branch, branch_address, inst_ready, inst_rdata);
      #1;
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] rd);
      rst = 1'b1; stall = st; is_branch = br; branch_address = tgt;
      is_rst_IF_ID = 1'b0; inst_ready = rdy; inst_rdata = rd;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rst, stall, br;
      logic [31:0] tgt;
      logic        rsti, rdy;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr, pc4, inst;
      logic        vld;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(logic r, logic st, logic br, logic [31:0] tgt, logic rsti,
                               logic rdy, logic [31:0] rd, logic req, logic [31:0] addr,
                               logic [31:0] pc4, logic [31:0] inst, logic vld);
      vec_t v;
      v.rst = r; v.stall = st; v.br = br; v.tgt = tgt; v.rsti = rsti; v.rdy = rdy;
      v.rdata = rd; v.req = req; v.addr = addr; v.pc4 = pc4; v.inst = inst; v.vld = vld;
      vecs.push_back(v);
   endfunction

   initial begin
      //   rst st br tgt          rsti rdy rdata        req addr         pc4     inst     vld
      add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,   32'h0,   0); // reset
      add(1, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h0,        32'h0,   32'h0,   0); // IDLE->FETCH
      add(1, 0, 0, 32'h0,        0, 1, 32'hA0,       1, 32'h4,        32'h4,   32'hA0,  1);
      add(1, 0, 0, 32'h0,        0, 1, 32'hA4,       1, 32'h8,        32'h8,   32'hA4,  1);
      add(1, 1, 0, 32'h0,        0, 1, 32'hA8,       0, 32'h8,        32'h8,   32'hA4,  1); // complete under stall
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        32'h8,   32'hA4,  1);
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        32'hC,   32'hA8,  1); // skid released
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        32'h0,   32'h0,   0); // wait -> bubble
      add(1, 0, 0, 32'h0,        0, 1, 32'hAC,       1, 32'h10,       32'h10,  32'hAC,  1);
      add(1, 0, 1, 32'h100,      0, 0, 32'h0,        1, 32'h10,       32'h0,   32'h0,   0); // redirect, 0x10 in flight
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       32'h0,   32'h0,   0);
      add(1, 0, 0, 32'h0,        0, 1, 32'hDEAD,     1, 32'h100,      32'h0,   32'h0,   0); // drained word dropped
      add(1, 0, 0, 32'h0,        0, 1, 32'hB100,     1, 32'h104,      32'h104, 32'hB100,1);
      add(1, 0, 1, 32'h40,       0, 1, 32'hB104,     1, 32'h40,       32'h0,   32'h0,   0); // redirect with ready
      add(1, 0, 0, 32'h0,        0, 1, 32'hB40,      1, 32'h44,       32'h44,  32'hB40, 1);
      add(1, 1, 1, 32'h200,      1, 0, 32'h0,        1, 32'h44,       32'h44,  32'hB40, 1); // stalled branch ignored
      add(1, 1, 1, 32'h200,      1, 0, 32'h0,        1, 32'h44,       32'h44,  32'hB40, 1);
      add(1, 0, 1, 32'h200,      0, 0, 32'h0,        1, 32'h44,       32'h0,   32'h0,   0); // taken once unstalled
      add(1, 0, 0, 32'h0,        0, 1, 32'hEEEE,     1, 32'h200,      32'h0,   32'h0,   0);
      add(1, 0, 1, 32'hFFFFFFFC, 0, 1, 32'hB200,     1, 32'hFFFFFFFC, 32'h0,   32'h0,   0);
      add(1, 0, 0, 32'h0,        0, 1, 32'hCC,       1, 32'h0,        32'h0,   32'hCC,  1); // pc+4 wraps
      add(1, 0, 0, 32'h0,        0, 1, 32'hD0,       1, 32'h4,        32'h4,   32'hD0,  1);
      add(1, 0, 1, 32'h300,      0, 0, 32'h0,        1, 32'h4,        32'h0,   32'h0,   0); // into DISCARD
      add(0, 0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        32'h0,   32'h0,   0); // reset in DISCARD
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'h0,   32'h0,   0);
      add(1, 1, 0, 32'h0,        0, 1, 32'hE0,       0, 32'h0,        32'h0,   32'h0,   0); // HOLD
      add(1, 0, 1, 32'h80,       0, 0, 32'h0,        1, 32'h80,       32'h0,   32'h0,   0); // redirect out of HOLD
      add(1, 0, 0, 32'h0,        0, 1, 32'hE80,      1, 32'h84,       32'h84,  32'hE80, 1);
      add(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h84,       32'h0,   32'h0,   0); // flush request

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; stall = vecs[i].stall; is_branch = vecs[i].br;
         branch_address = vecs[i].tgt; is_rst_IF_ID = vecs[i].rsti;
         inst_ready = vecs[i].rdy; inst_rdata = vecs[i].rdata;
         tick();
         chk($sformatf("v%0d inst_req", i),    32'(inst_req),  32'(vecs[i].req));
         chk($sformatf("v%0d inst_addr", i),   inst_addr,      vecs[i].addr);
         chk($sformatf("v%0d pc_plus4_ID", i), pc_plus4_ID,    vecs[i].pc4);
         chk($sformatf("v%0d inst_ID", i),     inst_ID,        vecs[i].inst);
         chk($sformatf("v%0d valid_ID", i),    32'(valid_ID),  32'(vecs[i].vld));
         if (i == 1) begin
            chk("wrap first req",  32'(w_req), 32'h1);
            chk("wrap first addr", w_addr,     32'hFFFF_FFFC);
         end
         if (i == 2) begin
            chk("wrap pc_plus4_ID", w_pc4,      32'h0);
            chk("wrap inst_ID",     w_inst,     32'hA0);
            chk("wrap valid_ID",    32'(w_vld), 32'h1);
            chk("wrap next addr",   w_addr,     32'h0);
         end
      end

      // Drain with retargeting: a stalled branch is ignored, the last unstalled one wins.
      drive(0, 1, 32'h500, 0, 32'h0);  tick();
      chk("drain addr held", inst_addr, 32'h84);
      drive(1, 1, 32'h600, 0, 32'h0);  tick();
      chk("drain stalled addr", inst_addr, 32'h84);
      chk("drain stalled valid", 32'(valid_ID), 32'h0);
      drive(0, 1, 32'h700, 0, 32'h0);  tick();
      chk("drain retarget addr", inst_addr, 32'h84);
      drive(0, 0, 32'h0, 1, 32'hBAD);  tick();
      chk("drain done addr", inst_addr, 32'h700);
      chk("drain done valid", 32'(valid_ID), 32'h0);
      drive(0, 0, 32'h0, 1, 32'h777);  tick();
      chk("after drain pc4", pc_plus4_ID, 32'h704);
      chk("after drain inst", inst_ID, 32'h777);

      // ---------------- random traffic vs model ----------------
      rst = 1'b0; tick();
      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 99) != 0);
         stall          = ($urandom_range(0, 9) < 3);
         is_branch      = ($urandom_range(0, 99) < 15);
         is_rst_IF_ID   = ($urandom_range(0, 9) == 0);
         branch_address = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         inst_ready     = $urandom_range(0, 1) == 1;
         inst_rdata     = $urandom();
         tick();
         chk($sformatf("r%0d inst_req", c),    32'(inst_req), 32'(exp_req()));
         chk($sformatf("r%0d inst_addr", c),   inst_addr,     exp_addr());
         chk($sformatf("r%0d pc_plus4_ID", c), pc_plus4_ID,   e_pc4);
         chk($sformatf("r%0d inst_ID", c),     inst_ID,       e_inst);
         chk($sformatf("r%0d valid_ID", c),    32'(valid_ID), 32'(e_vld));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
